// File: rtl/alu_interfaz_serie.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_interfaz_serie: turns a 3-byte UART frame (A, B, opcode) into ALU    |
// | operands and sends the ALU result byte back to the UART transmitter.     |
// | Optional macro ALU_INTERFAZ_TIMEOUT_EN adds an inter-byte frame timeout. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_interfaz_serie #(
   parameter int TIMEOUT_CICLOS = 50000000,
   parameter int ANCHO_TIMEOUT  = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_dato,
   input  logic       rx_listo,
   input  logic       tx_ocupado,
   output logic [7:0] tx_dato,
   output logic       tx_inicio,
   output logic [7:0] nr1,
   output logic [7:0] nr2,
   output logic [5:0] operacion,
   input  logic [7:0] resultado,
   output logic       ocupado,
   output logic       descartado
);

   typedef enum logic [2:0] {
      ESP_A     = 3'd0,
      ESP_B     = 3'd1,
      ESP_OP    = 3'd2,
      CALC      = 3'd3,
      ENVIAR    = 3'd4,
      ESPERA_TX = 3'd5
   } estado_t;

   estado_t    r_estado,     w_estado_sig;
   logic [7:0] r_nr1,        w_nr1_sig;
   logic [7:0] r_nr2,        w_nr2_sig;
   logic [5:0] r_operacion,  w_operacion_sig;
   logic [7:0] r_tx_dato,    w_tx_dato_sig;
   logic       r_tx_inicio,  w_tx_inicio_sig;
   logic       r_descartado, w_descartado_sig;
   logic       r_visto,      w_visto_sig;
   logic [1:0] r_espera,     w_espera_sig;
   logic       w_timeout;
   logic       w_ocupado;

   generate
      if ((64'd1 << ANCHO_TIMEOUT) <= 64'(TIMEOUT_CICLOS)) begin : g_chk_ancho
         $error("ANCHO_TIMEOUT too narrow for TIMEOUT_CICLOS");
      end
   endgenerate

`ifdef ALU_INTERFAZ_TIMEOUT_EN
   localparam logic [ANCHO_TIMEOUT-1:0] c_limite = ANCHO_TIMEOUT'(TIMEOUT_CICLOS - 1);

   logic [ANCHO_TIMEOUT-1:0] r_cuenta;
   logic                     w_cuenta_act;

   // Count only idle cycles inside a partial frame; anything else clears.
   assign w_cuenta_act = ((r_estado == ESP_B) || (r_estado == ESP_OP)) && !rx_listo;
   assign w_timeout    = w_cuenta_act && (r_cuenta == c_limite);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cuenta <= '0;
      else if (w_cuenta_act && !w_timeout)
         r_cuenta <= r_cuenta + 1'b1;
      else
         r_cuenta <= '0;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_estado     <= ESP_A;
         r_nr1        <= '0;
         r_nr2        <= '0;
         r_operacion  <= '0;
         r_tx_dato    <= '0;
         r_tx_inicio  <= 1'b0;
         r_descartado <= 1'b0;
         r_visto      <= 1'b0;
         r_espera     <= '0;
      end else begin
         r_estado     <= w_estado_sig;
         r_nr1        <= w_nr1_sig;
         r_nr2        <= w_nr2_sig;
         r_operacion  <= w_operacion_sig;
         r_tx_dato    <= w_tx_dato_sig;
         r_tx_inicio  <= w_tx_inicio_sig;
         r_descartado <= w_descartado_sig;
         r_visto      <= w_visto_sig;
         r_espera     <= w_espera_sig;
      end
   end

   always_comb begin
      w_estado_sig     = r_estado;
      w_nr1_sig        = r_nr1;
      w_nr2_sig        = r_nr2;
      w_operacion_sig  = r_operacion;
      w_tx_dato_sig    = r_tx_dato;
      w_tx_inicio_sig  = 1'b0;
      w_descartado_sig = 1'b0;
      w_visto_sig      = r_visto;
      w_espera_sig     = r_espera;

      case (r_estado)
         ESP_A: begin
            if (rx_listo) begin
               w_nr1_sig    = rx_dato;
               w_estado_sig = ESP_B;
            end
         end
         ESP_B: begin
            if (rx_listo) begin
               w_nr2_sig    = rx_dato;
               w_estado_sig = ESP_OP;
            end else if (w_timeout) begin
               w_estado_sig     = ESP_A;
               w_descartado_sig = 1'b1;
            end
         end
         ESP_OP: begin
            if (rx_listo) begin
               w_operacion_sig = rx_dato[5:0];
               w_estado_sig    = CALC;
            end else if (w_timeout) begin
               w_estado_sig     = ESP_A;
               w_descartado_sig = 1'b1;
            end
         end
         // The start pulse is registered, so the free-transmitter decision of
         // ENVIAR is taken here already to reach the result in two cycles.
         CALC: begin
            w_descartado_sig = rx_listo;
            w_tx_dato_sig    = resultado;
            if (!tx_ocupado) begin
               w_tx_inicio_sig = 1'b1;
               w_visto_sig     = 1'b0;
               w_espera_sig    = '0;
               w_estado_sig    = ESPERA_TX;
            end else begin
               w_estado_sig    = ENVIAR;
            end
         end
         ENVIAR: begin
            w_descartado_sig = rx_listo;
            if (!tx_ocupado) begin
               w_tx_inicio_sig = 1'b1;
               w_visto_sig     = 1'b0;
               w_espera_sig    = '0;
               w_estado_sig    = ESPERA_TX;
            end
         end
         ESPERA_TX: begin
            w_descartado_sig = rx_listo;
            if (tx_ocupado)
               w_visto_sig = 1'b1;
            else if (r_visto || (r_espera == 2'd2))
               w_estado_sig = ESP_A;
            else
               w_espera_sig = r_espera + 2'd1;
         end
         default: w_estado_sig = ESP_A;
      endcase
   end

   assign w_ocupado  = (r_estado == CALC) || (r_estado == ENVIAR) || (r_estado == ESPERA_TX);

   assign nr1        = r_nr1;
   assign nr2        = r_nr2;
   assign operacion  = r_operacion;
   assign tx_dato    = r_tx_dato;
   assign tx_inicio  = r_tx_inicio;
   assign descartado = r_descartado;
   assign ocupado    = w_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_alu_interfaz_serie.sv
`default_nettype none
// Directed bench for alu_interfaz_serie with a small MIPS-funct style ALU model.
module tb_alu_interfaz_serie;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_dato;
   logic       rx_listo;
   logic       tx_ocupado;
   logic [7:0] tx_dato;
   logic       tx_inicio;
   logic [7:0] nr1;
   logic [7:0] nr2;
   logic [5:0] operacion;
   logic [7:0] resultado;
   logic       ocupado;
   logic       descartado;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   alu_interfaz_serie #(
      .TIMEOUT_CICLOS(20),
      .ANCHO_TIMEOUT (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_dato   (rx_dato),
      .rx_listo  (rx_listo),
      .tx_ocupado(tx_ocupado),
      .tx_dato   (tx_dato),
      .tx_inicio (tx_inicio),
      .nr1       (nr1),
      .nr2       (nr2),
      .operacion (operacion),
      .resultado (resultado),
      .ocupado   (ocupado),
      .descartado(descartado)
   );

   always_comb begin
      resultado = 8'h00;
      case (operacion)
         6'h00: resultado = nr1 << nr2[2:0];
         6'h02: resultado = nr1 >> nr2[2:0];
         6'h03: resultado = 8'($signed(nr1) >>> nr2[2:0]);
         6'h20: resultado = nr1 + nr2;
         6'h22: resultado = nr1 - nr2;
         6'h24: resultado = nr1 & nr2;
         6'h25: resultado = nr1 | nr2;
         6'h26: resultado = nr1 ^ nr2;
         6'h27: resultado = ~(nr1 | nr2);
         default: resultado = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_dato  = b;
      rx_listo = 1'b1;
      @(negedge clk);
      rx_listo = 1'b0;
   endtask

   // Called mid-cycle right after the opcode byte was taken.
   task automatic expect_result(input string tag, input logic [7:0] exp);
      check({tag, "_pre"}, 32'(tx_inicio), 32'd0);
      @(negedge clk);
      check({tag, "_ini"}, 32'(tx_inicio), 32'd1);
      check({tag, "_dato"}, 32'(tx_dato), 32'(exp));
      check({tag, "_ocup"}, 32'(ocupado), 32'd1);
      @(negedge clk);
      check({tag, "_post"}, 32'(tx_inicio), 32'd0);
      check({tag, "_hold"}, 32'(tx_dato), 32'(exp));
      repeat (3) @(negedge clk);
      check({tag, "_idle"}, 32'(ocupado), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      rx_dato    = 8'h00;
      rx_listo   = 1'b0;
      tx_ocupado = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_nr1", 32'(nr1), 32'd0);
      check("rst_nr2", 32'(nr2), 32'd0);
      check("rst_op", 32'(operacion), 32'd0);
      check("rst_txd", 32'(tx_dato), 32'd0);
      check("rst_txi", 32'(tx_inicio), 32'd0);
      check("rst_desc", 32'(descartado), 32'd0);
      check("rst_ocup", 32'(ocupado), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send_byte(8'h0F); send_byte(8'h0F); send_byte(8'h20);
      check("add_nr1", 32'(nr1), 32'h0F);
      check("add_nr2", 32'(nr2), 32'h0F);
      check("add_op", 32'(operacion), 32'h20);
      expect_result("add", 8'h1E);

      send_byte(8'h06); send_byte(8'h02); send_byte(8'h22);
      expect_result("sub", 8'h04);
      send_byte(8'h86); send_byte(8'h04); send_byte(8'h03);
      expect_result("sra", 8'hF8);

      // Backpressure, with an overrun byte injected while waiting in ENVIAR
      @(negedge clk);
      tx_ocupado = 1'b1;
      send_byte(8'h06); send_byte(8'h02); send_byte(8'h24);
      check("bp_op", 32'(operacion), 32'h24);
      @(negedge clk);
      check("bp_c0", 32'(tx_inicio), 32'd0);
      check("bp_ocup", 32'(ocupado), 32'd1);
      rx_dato  = 8'hAA;
      rx_listo = 1'b1;
      @(negedge clk);
      rx_listo = 1'b0;
      check("bp_c1", 32'(tx_inicio), 32'd0);
      check("ovr_desc", 32'(descartado), 32'd1);
      @(negedge clk);
      check("ovr_desc_end", 32'(descartado), 32'd0);
      check("ovr_nr1", 32'(nr1), 32'h06);
      check("bp_c2", 32'(tx_inicio), 32'd0);
      @(negedge clk);
      check("bp_c3", 32'(tx_inicio), 32'd0);
      @(negedge clk);
      check("bp_c4", 32'(tx_inicio), 32'd0);
      tx_ocupado = 1'b0;
      @(negedge clk);
      check("bp_ini", 32'(tx_inicio), 32'd1);
      check("bp_dato", 32'(tx_dato), 32'h02);
      tx_ocupado = 1'b1;
      @(negedge clk);
      check("bp_post", 32'(tx_inicio), 32'd0);
      check("bp_wait1", 32'(ocupado), 32'd1);
      repeat (2) @(negedge clk);
      check("bp_wait3", 32'(ocupado), 32'd1);
      tx_ocupado = 1'b0;
      @(negedge clk);
      check("bp_done", 32'(ocupado), 32'd0);

      send_byte(8'h06); send_byte(8'h02); send_byte(8'h25);
      expect_result("or", 8'h06);

      // Asynchronous reset in the middle of a frame
      send_byte(8'h11); send_byte(8'h22);
      check("mid_nr1", 32'(nr1), 32'h11);
      check("mid_nr2", 32'(nr2), 32'h22);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_nr1", 32'(nr1), 32'd0);
      check("arst_nr2", 32'(nr2), 32'd0);
      check("arst_op", 32'(operacion), 32'd0);
      check("arst_txd", 32'(tx_dato), 32'd0);
      check("arst_ocup", 32'(ocupado), 32'd0);
      #1 rst_n = 1'b1;
      send_byte(8'h06); send_byte(8'h02); send_byte(8'h26);
      expect_result("xor", 8'h04);

      // Partial frame followed by a long idle gap
      send_byte(8'h33);
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (descartado) pulses++;
      end
`ifdef ALU_INTERFAZ_TIMEOUT_EN
      check("to_pulses", 32'(pulses), 32'd1);
      check("to_nr1", 32'(nr1), 32'h33);
      send_byte(8'h06); send_byte(8'h02); send_byte(8'h27);
      expect_result("nor", 8'hF9);
`else
      check("to_pulses", 32'(pulses), 32'd0);
      send_byte(8'h06); send_byte(8'h02);
      check("nto_nr1", 32'(nr1), 32'h33);
      check("nto_nr2", 32'(nr2), 32'h06);
      check("nto_op", 32'(operacion), 32'h02);
      expect_result("srl", 8'h00);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_interfaz_serie.md
Name: alu_interfaz_serie

Overview:
- Byte-stream front end that drives the 8-bit ALU (`nr1`, `nr2`, `operacion` in; `resultado` out).
- Upstream is the UART receiver; it delivers frames of three bytes: operand A, operand B, opcode.
- The block registers the three operands onto the ALU inputs, samples the combinational result one cycle later, and hands the result byte to the UART transmitter.
- It is the producer/consumer end of the ALU operand/result interface.

Parameters:
- `TIMEOUT_CICLOS`, default 50000000: idle cycles allowed between bytes of one frame. Used only when the optional feature is compiled in.
- `ANCHO_TIMEOUT`, default 26: width of the timeout counter. Must satisfy 2^ANCHO_TIMEOUT > TIMEOUT_CICLOS.

Ports:
- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_dato` input 8: received byte.
- `rx_listo` input 1: one-cycle pulse; `rx_dato` is valid in that cycle.
- `tx_ocupado` input 1: transmitter busy; high means the transmitter cannot accept a byte.
- `tx_dato` output 8: byte to transmit. Held stable from the `tx_inicio` cycle until the next frame's result.
- `tx_inicio` output 1: one-cycle start pulse to the transmitter.
- `nr1` output 8: ALU operand A (registered).
- `nr2` output 8: ALU operand B (registered).
- `operacion` output 6: ALU opcode, taken from `rx_dato[5:0]` of the third byte (registered).
- `resultado` input 8: combinational ALU result.
- `ocupado` output 1: high in states CALC, ENVIAR and ESPERA_TX.
- `descartado` output 1: one-cycle pulse when an incoming byte is dropped.

Behaviour:
- Reset (async, `rst_n` low): state = ESP_A. `nr1`, `nr2`, `operacion`, `tx_dato` = 0. `tx_inicio`, `descartado`, `ocupado` = 0. Timeout counter = 0. Reset asserted mid-frame or mid-send aborts with no pulse emitted.
- ESP_A: on `rx_listo`, `nr1` <= `rx_dato`, go to ESP_B.
- ESP_B: on `rx_listo`, `nr2` <= `rx_dato`, go to ESP_OP.
- ESP_OP: on `rx_listo`, `operacion` <= `rx_dato[5:0]`, go to CALC. `rx_dato[7:6]` are ignored.
- CALC (exactly 1 cycle): ALU inputs are now stable. `tx_dato` <= `resultado`, go to ENVIAR.
- ENVIAR:
  - If `tx_ocupado` = 0: `tx_inicio` = 1 for this one cycle, go to ESPERA_TX.
  - Otherwise stay in ENVIAR with `tx_inicio` = 0 until the transmitter is free.
- ESPERA_TX: wait for `tx_ocupado` to rise, then fall; then go to ESP_A. If `tx_ocupado` never rises within 2 cycles of `tx_inicio`, go to ESP_A (transmitter latched and finished instantly).
- Latency: `rx_listo` of the opcode byte in cycle N gives `tx_inicio` in cycle N+2 at the earliest (transmitter idle).
- `nr1`, `nr2`, `operacion` hold their values after the send until overwritten by the next frame. The ALU therefore keeps showing the last operation.
- `tx_inicio` and `descartado` are registered outputs; both are 0 in every cycle where not explicitly pulsed.
- `rx_listo` while in CALC, ENVIAR or ESPERA_TX: the byte is dropped, `descartado` pulses 1 cycle, state is unchanged, and no operand is modified.
- `rx_listo` coinciding with `tx_ocupado` changes: no interaction. Each is handled by its own state rule above.
- The opcode is passed through undecoded. Unsupported codes produce whatever the ALU outputs. The block does not validate.

Optional Feature:
- Macro: `ALU_INTERFAZ_TIMEOUT_EN`.
- Defined:
  - Counter clears on every accepted byte and on entry to ESP_A.
  - Counter increments each cycle in ESP_B or ESP_OP.
  - On reaching `TIMEOUT_CICLOS`: state = ESP_A, counter = 0, `descartado` pulses once.
  - `nr1` and `nr2` keep their partial values; no transmission is made.
- Not defined: no counter logic is synthesized. A partial frame waits indefinitely for its remaining bytes.

Test Plan:
- Addition: send 0x0F, 0x0F, 0x20 with transmitter idle. Expect `nr1` = `nr2` = 0x0F, `operacion` = 6'h20, and one `tx_inicio` pulse 2 cycles after the third `rx_listo` with `tx_dato` = 0x1E.
- Subtraction and shift: send 0x06, 0x02, 0x22; expect `tx_dato` = 0x04. Then send 0x86, 0x04, 0x03 (SRA); expect `tx_dato` = 0xF8 per the ALU model.
- Transmitter backpressure: hold `tx_ocupado` = 1 for 5 cycles before frame 0x06, 0x02, 0x24 completes. Expect `tx_inicio` to stay low during those cycles, then pulse exactly once with `tx_dato` = 0x02 in the cycle after `tx_ocupado` falls.
- Overrun: send a byte 0xAA while in ENVIAR/ESPERA_TX. Expect `descartado` to pulse 1 cycle and `nr1` to be unchanged. The next full frame 0x06, 0x02, 0x25 returns 0x06.
- Reset mid-frame: send 0x11, 0x22, then pulse `rst_n` low asynchronously between clock edges. Expect all outputs to be 0 immediately and state ESP_A. Frame 0x06, 0x02, 0x26 then returns 0x04.
- Timeout (with `ALU_INTERFAZ_TIMEOUT_EN`, `TIMEOUT_CICLOS` = 20): send 0x33, then idle 20 cycles. Expect one `descartado` pulse and state ESP_A. Then 0x06, 0x02, 0x27 returns 0xF9. Without the macro, the same idle produces no pulse and 0x06 is taken as operand B.
